// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory-access sequencer: one read/write at a time, MAR/MDR strobes,
// memory handshake with bounded wait, done/err completion pulses.
//
// state    | meaning
// S_IDLE   | waiting for req; captures we/data_size/addr0
// S_SETUP  | load MAR (and MDR from bus on writes)
// S_ACCESS | memory enabled, waiting for mem_ready or timeout
// S_DONE   | one-cycle done pulse
// S_ERR    | one-cycle err pulse (misaligned or timeout)
module lc3b_mem_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic we,
    input  logic data_size,
    input  logic addr0,
    input  logic mem_ready,
    output logic ld_mar,
    output logic ld_mdr,
    output logic mio_en,
    output logic mem_en,
    output logic mem_rw,
    output logic we0,
    output logic we1,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic             size_q, size_d;
    logic             a0_q, a0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            a0_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            a0_q    <= a0_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        a0_d    = a0_q;
        cnt_d   = cnt_q;
        ld_mar  = 1'b0;
        ld_mdr  = 1'b0;
        mio_en  = 1'b0;
        mem_en  = 1'b0;
        mem_rw  = 1'b0;
        we0     = 1'b0;
        we1     = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    we_d    = we;
                    size_d  = data_size;
                    a0_d    = addr0;
                    cnt_d   = '0;
                    state_d = (!data_size && addr0) ? S_ERR : S_SETUP;
                end
            end
            S_SETUP: begin
                ld_mar  = 1'b1;
                ld_mdr  = we_q;
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                mem_en = 1'b1;
                mem_rw = we_q;
                // Word writes enable both lanes; byte writes pick the lane from addr0.
                we0    = we_q && (!size_q || !a0_q);
                we1    = we_q && (!size_q || a0_q);
                if (mem_ready) begin
                    ld_mdr  = !we_q;
                    mio_en  = !we_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Bench for lc3b_mem_ctrl: transaction-level reference model compared every
// cycle, directed scenarios with literal latency checks, then random traffic.
module tb_lc3b_mem_ctrl;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0, we = 1'b0, data_size = 1'b0, addr0 = 1'b0, mem_ready = 1'b0;
    logic ld_mar, ld_mdr, mio_en, mem_en, mem_rw, we0, we1, busy, done, err;

    lc3b_mem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .data_size(data_size),
        .addr0(addr0), .mem_ready(mem_ready), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .mem_en(mem_en), .mem_rw(mem_rw), .we0(we0), .we1(we1),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a transaction in flight, t = cycles since acceptance,
    // m_end = 0 running, 1 completing, 2 failing.
    bit m_active = 0, m_wr = 0, m_byte = 0, m_a0 = 0;
    int m_t = 0, m_end = 0;
    int cyc = 0, acc_cyc = 0;

    int done_lat, err_lat, en_cnt, mar_cnt, mdr_cnt;
    int done_cycles[$];

    function automatic logic [9:0] model_out();
        logic mar = 0, mdr = 0, mio = 0, en = 0, rw = 0, w0 = 0, w1 = 0, d = 0, e = 0;
        logic b = rst_n && m_active;
        if (b) begin
            if (m_end == 1) d = 1;
            else if (m_end == 2) e = 1;
            else if (m_t == 1) begin
                mar = 1;
                mdr = m_wr;
            end else begin
                en  = 1;
                rw  = m_wr;
                w0  = m_wr && !(m_byte && m_a0);
                w1  = m_wr && !(m_byte && !m_a0);
                mdr = !m_wr && mem_ready;
                mio = mdr;
            end
        end
        return {mar, mdr, mio, en, rw, w0, w1, b, d, e};
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_active = 0;
        end else if (!m_active) begin
            if (req) begin
                m_active = 1;
                m_wr     = we;
                m_byte   = data_size;
                m_a0     = addr0;
                m_t      = 1;
                m_end    = (!data_size && addr0) ? 2 : 0;
                acc_cyc  = cyc;
            end
        end else if (m_end != 0) begin
            m_active = 0;
        end else if (m_t == 1) begin
            m_t = 2;
        end else if (mem_ready) begin
            m_end = 1;
        end else if (m_t - 1 == TIMEOUT) begin
            m_end = 2;
        end else begin
            m_t++;
        end
        cyc++;
    endtask

    task automatic check();
        logic [9:0] exp_v, act_v;
        exp_v = model_out();
        act_v = {ld_mar, ld_mdr, mio_en, mem_en, mem_rw, we0, we1, busy, done, err};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d {mar,mdr,mio,en,rw,we0,we1,busy,done,err} actual=%b required=%b",
                     cyc, act_v, exp_v);
        end
        if (done === 1'b1) begin
            done_lat = cyc - acc_cyc;
            done_cycles.push_back(cyc);
        end
        if (err === 1'b1) err_lat = cyc - acc_cyc;
        if (mem_en === 1'b1) en_cnt++;
        if (ld_mar === 1'b1) mar_cnt++;
        if (ld_mdr === 1'b1) mdr_cnt++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic s, input logic a, input logic rdy);
        req = r; we = w; data_size = s; addr0 = a; mem_ready = rdy;
    endtask

    task automatic clear_obs();
        done_lat = -1; err_lat = -1; en_cnt = 0; mar_cnt = 0; mdr_cnt = 0;
        done_cycles.delete();
    endtask

    task automatic pin(input string name, input int act, input int req_v);
        vectors++;
        if (act != req_v) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    initial begin
        int start;
        int mode;
        clear_obs();

        // Reset state
        repeat (2) run_cycle();
        rst_n = 1'b1;
        run_cycle();

        // Zero-wait word read
        clear_obs();
        drive(1, 0, 0, 0, 1); run_cycle();
        drive(0, 0, 0, 0, 1); repeat (4) run_cycle();
        pin("rd0_done_lat", done_lat, 3);
        pin("rd0_mem_en_cycles", en_cnt, 1);
        pin("rd0_ld_mdr_cycles", mdr_cnt, 1);

        // Byte write high lane, ready on 3rd ACCESS cycle
        clear_obs();
        drive(1, 1, 1, 1, 0); run_cycle();
        drive(0, 1, 1, 1, 0);
        for (int k = 0; k < 6; k++) begin
            mem_ready = (cyc - acc_cyc == 4);
            run_cycle();
        end
        pin("bw_done_lat", done_lat, 5);
        pin("bw_mem_en_cycles", en_cnt, 3);

        // Misaligned word read
        clear_obs();
        drive(1, 0, 0, 1, 1); run_cycle();
        drive(0, 0, 0, 0, 1); repeat (3) run_cycle();
        pin("mis_err_lat", err_lat, 1);
        pin("mis_ld_mar", mar_cnt, 0);
        pin("mis_mem_en", en_cnt, 0);
        pin("mis_done", done_lat, -1);

        // Timeout, then follow-up read
        clear_obs();
        drive(1, 0, 0, 0, 0); run_cycle();
        drive(0, 0, 0, 0, 0); repeat (18) run_cycle();
        pin("to_err_lat", err_lat, 17);
        pin("to_ld_mdr", mdr_cnt, 0);
        pin("to_mem_en_cycles", en_cnt, TIMEOUT);
        clear_obs();
        drive(1, 0, 0, 0, 1); run_cycle();
        drive(0, 0, 0, 0, 1); repeat (4) run_cycle();
        pin("to_followup_done_lat", done_lat, 3);

        // Reset abort during 2nd ACCESS cycle
        clear_obs();
        drive(1, 1, 0, 0, 0); run_cycle();
        drive(0, 1, 0, 0, 0); repeat (2) run_cycle();
        #2 rst_n = 1'b0;
        #1;
        pin("abort_outputs_zero",
            int'({ld_mar, ld_mdr, mio_en, mem_en, mem_rw, we0, we1, busy, done, err}), 0);
        repeat (2) run_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 1'($urandom_range(0, 1)));
            run_cycle();
        end
        pin("abort_no_done", done_lat, -1);
        pin("abort_no_err", err_lat, -1);

        // Back-to-back with req high at each IDLE, junk req/we while busy
        clear_obs();
        drive(1, 0, 0, 0, 1); run_cycle();
        start = acc_cyc;
        for (int k = 1; k <= 8; k++) begin
            req = (k == 4) ? 1'b1 : ((k == 8) ? 1'b0 : 1'($urandom_range(0, 1)));
            we  = (k == 4) ? 1'b0 : 1'($urandom_range(0, 1));
            run_cycle();
        end
        pin("b2b_done_count", done_cycles.size(), 2);
        if (done_cycles.size() >= 2) begin
            pin("b2b_done1_cycle", done_cycles[0] - start, 3);
            pin("b2b_done2_cycle", done_cycles[1] - start, 7);
        end

        // Random traffic with varying ready probability
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            mode = (k / 250) % 4;
            req       = ($urandom_range(0, 2) == 0);
            we        = 1'($urandom_range(0, 1));
            data_size = 1'($urandom_range(0, 1));
            addr0     = 1'($urandom_range(0, 1));
            case (mode)
                0: mem_ready = 1'b1;
                1: mem_ready = ($urandom_range(0, 3) == 0);
                2: mem_ready = ($urandom_range(0, 31) == 0);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                pin("rand_async_reset_zero",
                    int'({ld_mar, ld_mdr, mio_en, mem_en, mem_rw, we0, we1, busy, done, err}), 0);
                run_cycle();
                rst_n = 1'b1;
            end else begin
                run_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
